// File: rtl/hist2d_accum_ctrl_if.sv
// Handshake bundle for hist2d_accum_ctrl: bin coordinate input
// (valid/ready) and histogram dump output (valid/ready/last).
interface hist2d_accum_ctrl_if #(
  parameter int COORD_W = 6,
  parameter int COUNT_W = 16
);
  logic               bin_valid;
  logic               bin_ready;
  logic [COORD_W-1:0] i_bin_coord;
  logic [COORD_W-1:0] q_bin_coord;
  logic               dump_valid;
  logic               dump_ready;
  logic [COORD_W-1:0] dump_i;
  logic [COORD_W-1:0] dump_q;
  logic [COUNT_W-1:0] dump_count;
  logic               dump_last;

  modport master (
    output bin_valid, i_bin_coord, q_bin_coord, dump_ready,
    input  bin_ready, dump_valid, dump_i, dump_q,
    input  dump_count, dump_last
  );

  modport slave (
    input  bin_valid, i_bin_coord, q_bin_coord, dump_ready,
    output bin_ready, dump_valid, dump_i, dump_q,
    output dump_count, dump_last
  );
endinterface

// File: rtl/hist2d_accum_ctrl.sv
// 2D IQ histogram sequencer: owns the count RAM and arbitrates clear
// sweep, read-modify-write accumulation and ordered dump streaming.
// Ports: clk100, rst_n (async low), clear, i/q_bin_num, dump_req,
//   bus (slave: bin valid/ready + coords, dump valid/ready/i/q/count/last),
//   busy, sat_flag, oor_count, total_count.
// Option: define HIST_CLEAR_ON_DUMP_EN to zero each bin as it is dumped.
module hist2d_accum_ctrl #(
  parameter int COORD_W = 6,
  parameter int COUNT_W = 16,
  parameter int TOTAL_W = 32
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [COORD_W-1:0] i_bin_num,
  input  logic [COORD_W-1:0] q_bin_num,
  input  logic               dump_req,
  hist2d_accum_ctrl_if.slave bus,
  output logic               busy,
  output logic               sat_flag,
  output logic [COUNT_W-1:0] oor_count,
  output logic [TOTAL_W-1:0] total_count
);

  localparam int AW = 2 * COORD_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [COORD_W-1:0] NUM_MIN = COORD_W'(1);

  typedef enum logic [2:0] {
    CLEAR, IDLE, ACC_RD, ACC_WAIT,
    ACC_WR, DMP_RD, DMP_WAIT, DMP_OUT
  } state_t;

  state_t state, nxt;

  logic [COUNT_W-1:0] mem [DEPTH];
  logic [COUNT_W-1:0] rdata;
  logic [AW-1:0]      mem_addr;
  logic               mem_we;
  logic               mem_re;
  logic [COUNT_W-1:0] mem_wdata;

  logic [AW-1:0]      clr_addr;
  logic [AW-1:0]      acc_addr;
  logic [COORD_W-1:0] inum, qnum;
  logic [COORD_W-1:0] cur_i, cur_q;
  logic [COUNT_W-1:0] cnt_q;

  logic accept, in_range, dmp_end, hs;

  assign busy = (state != IDLE);
  assign bus.bin_ready = (state == IDLE) && !clear && !dump_req;
  assign bus.dump_valid = (state == DMP_OUT);
  assign bus.dump_last = (state == DMP_OUT) && dmp_end;
  assign bus.dump_i = cur_i;
  assign bus.dump_q = cur_q;
  assign bus.dump_count = cnt_q;

  assign accept = bus.bin_valid && bus.bin_ready;
  assign in_range = (bus.i_bin_coord < inum) &&
                    (bus.q_bin_coord < qnum);
  assign dmp_end = (cur_i == inum - 1'b1) &&
                   (cur_q == qnum - 1'b1);
  assign hs = (state == DMP_OUT) && bus.dump_ready;

  always_comb begin
    nxt = state;
    mem_addr = '0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    mem_wdata = '0;
    unique case (state)
      CLEAR: begin
        mem_addr = clr_addr;
        mem_we = 1'b1;
        if (clr_addr == LAST_ADDR) nxt = IDLE;
      end
      IDLE: begin
        if (dump_req) nxt = DMP_RD;
        else if (accept && in_range) nxt = ACC_RD;
      end
      // ACC_RD read returns in time for ACC_WR, giving a
      // 3-cycle sample; ACC_WAIT is never entered.
      ACC_RD: begin
        mem_addr = acc_addr;
        mem_re = 1'b1;
        nxt = ACC_WR;
      end
      ACC_WAIT: nxt = ACC_WR;
      ACC_WR: begin
        mem_addr = acc_addr;
        mem_we = 1'b1;
        mem_wdata = (rdata == '1) ? rdata : rdata + 1'b1;
        nxt = IDLE;
      end
      DMP_RD: begin
        mem_addr = {cur_i, cur_q};
        mem_re = 1'b1;
        nxt = DMP_WAIT;
      end
      DMP_WAIT: nxt = DMP_OUT;
      DMP_OUT: begin
        if (bus.dump_ready) begin
`ifdef HIST_CLEAR_ON_DUMP_EN
          mem_addr = {cur_i, cur_q};
          mem_we = 1'b1;
`endif
          nxt = dmp_end ? IDLE : DMP_RD;
        end
      end
      default: nxt = CLEAR;
    endcase
    // clear aborts anything, including an in-flight write
    if (clear) begin
      nxt = CLEAR;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk100) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) rdata <= mem[mem_addr];
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else state <= nxt;
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr <= '0;
      acc_addr <= '0;
      inum <= NUM_MIN;
      qnum <= NUM_MIN;
      cur_i <= '0;
      cur_q <= '0;
      cnt_q <= '0;
      sat_flag <= 1'b0;
      oor_count <= '0;
      total_count <= '0;
    end else if (clear) begin
      clr_addr <= '0;
      inum <= (i_bin_num == '0) ? NUM_MIN : i_bin_num;
      qnum <= (q_bin_num == '0) ? NUM_MIN : q_bin_num;
      sat_flag <= 1'b0;
      oor_count <= '0;
      total_count <= '0;
    end else begin
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (accept) begin
        acc_addr <= {bus.i_bin_coord, bus.q_bin_coord};
        if (total_count != '1)
          total_count <= total_count + 1'b1;
        if (!in_range && oor_count != '1)
          oor_count <= oor_count + 1'b1;
      end
      if (state == ACC_WR && rdata == '1) sat_flag <= 1'b1;
      if (state == IDLE && dump_req) begin
        cur_i <= '0;
        cur_q <= '0;
      end
      if (state == DMP_WAIT) cnt_q <= rdata;
      if (hs && !dmp_end) begin
        if (cur_q == qnum - 1'b1) begin
          cur_q <= '0;
          cur_i <= cur_i + 1'b1;
        end else begin
          cur_q <= cur_q + 1'b1;
        end
      end
`ifdef HIST_CLEAR_ON_DUMP_EN
      if (hs && dmp_end) begin
        sat_flag <= 1'b0;
        oor_count <= '0;
        total_count <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_hist2d_accum_ctrl.sv
// Scoreboard bench for hist2d_accum_ctrl: behavioural histogram model,
// expected dump words queued at request time, monitor pops on handshake.
module tb_hist2d_accum_ctrl;

  localparam int CW = 6;
  localparam int NW = 8;
  localparam int TW = 32;
  localparam int NMAX = (1 << NW) - 1;

  logic clk100 = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic dump_req = 1'b0;
  logic [CW-1:0] i_bin_num = '0;
  logic [CW-1:0] q_bin_num = '0;
  logic busy, sat_flag;
  logic [NW-1:0] oor_count;
  logic [TW-1:0] total_count;

  hist2d_accum_ctrl_if #(.COORD_W(CW), .COUNT_W(NW)) bus ();

  hist2d_accum_ctrl #(
    .COORD_W(CW), .COUNT_W(NW), .TOTAL_W(TW)
  ) dut (
    .clk100(clk100), .rst_n(rst_n), .clear(clear),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .dump_req(dump_req), .bus(bus), .busy(busy),
    .sat_flag(sat_flag), .oor_count(oor_count),
    .total_count(total_count)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    int i;
    int q;
    int c;
    bit last;
  } word_t;

  word_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_t[$];

  int m_cnt[4096];
  int mi = 1, mq = 1;
  int m_oor = 0, m_sat = 0;
  longint m_total = 0;

  always @(posedge clk100) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // monitor: hold stability while stalled, pop on handshake
  bit held = 0;
  int h_i, h_q, h_c, h_l;
  always @(negedge clk100) begin
    if (rst_n && bus.dump_valid) begin
      if (held) begin
        checks++;
        if (bus.dump_i != h_i || bus.dump_q != h_q ||
            bus.dump_count != h_c || bus.dump_last != h_l) begin
          errors++;
          $display("FAIL dump_hold act=(%0d,%0d,%0d,%0d) exp=(%0d,%0d,%0d,%0d)",
            bus.dump_i, bus.dump_q, bus.dump_count, bus.dump_last,
            h_i, h_q, h_c, h_l);
        end
      end
      if (bus.dump_ready) begin
        word_t e;
        held = 0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dump_extra act=(%0d,%0d) exp=none",
            bus.dump_i, bus.dump_q);
        end else begin
          e = sb.pop_front();
          if (bus.dump_i != e.i || bus.dump_q != e.q ||
              bus.dump_count != e.c || bus.dump_last != e.last) begin
            errors++;
            $display("FAIL dump_word act=(%0d,%0d,%0d,%0d) exp=(%0d,%0d,%0d,%0d)",
              bus.dump_i, bus.dump_q, bus.dump_count, bus.dump_last,
              e.i, e.q, e.c, e.last);
          end
        end
      end else begin
        held = 1;
        h_i = bus.dump_i;
        h_q = bus.dump_q;
        h_c = bus.dump_count;
        h_l = bus.dump_last;
      end
    end else begin
      held = 0;
    end
  end

  task automatic model_clear(int a, int b);
    mi = (a == 0) ? 1 : a;
    mq = (b == 0) ? 1 : b;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_oor = 0;
    m_sat = 0;
    m_total = 0;
  endtask

  task automatic model_accept(int i, int q);
    m_total++;
    if (i >= mi || q >= mq) begin
      if (m_oor < NMAX) m_oor++;
    end else if (m_cnt[i*64+q] == NMAX) begin
      m_sat = 1;
    end else begin
      m_cnt[i*64+q]++;
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (n < 5000) begin
      @(negedge clk100);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic do_clear(int a, int b, string nm);
    int n;
    @(posedge clk100); #1;
    clear = 1'b1;
    i_bin_num = CW'(a);
    q_bin_num = CW'(b);
    @(posedge clk100); #1;
    clear = 1'b0;
    model_clear(a, b);
    count_busy(n);
    chk(nm, n, 4096);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk100);
      t++;
    end while (busy && t < 100);
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic send_burst(int n, int i, int q);
    int got = 0;
    int w = 0;
    @(posedge clk100); #1;
    bus.bin_valid = 1'b1;
    bus.i_bin_coord = CW'(i);
    bus.q_bin_coord = CW'(q);
    while (got < n) begin
      @(negedge clk100);
      if (bus.bin_ready) begin
        model_accept(i, q);
        acc_t.push_back(cyc);
        got++;
        w = 0;
        @(posedge clk100); #1;
      end else begin
        w++;
        if (w > 50) begin
          chk("bin_ready_timeout", 0, 1);
          break;
        end
      end
    end
    bus.bin_valid = 1'b0;
  endtask

  task automatic chk_counters(string nm);
    wait_idle();
    chk({nm, "_total"}, total_count, m_total);
    chk({nm, "_oor"}, oor_count, m_oor);
    chk({nm, "_sat"}, sat_flag, m_sat);
  endtask

  function automatic bit pat(int mode, int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic push_expected();
    for (int i = 0; i < mi; i++)
      for (int q = 0; q < mq; q++) begin
        word_t w;
        w.i = i;
        w.q = q;
        w.c = m_cnt[i*64+q];
        w.last = (i == mi - 1) && (q == mq - 1);
        sb.push_back(w);
      end
  endtask

  task automatic do_dump(int mode);
    int k = 0;
    int bound = mi * mq * 16 + 50;
    push_expected();
`ifdef HIST_CLEAR_ON_DUMP_EN
    for (int i = 0; i < mi; i++)
      for (int q = 0; q < mq; q++) m_cnt[i*64+q] = 0;
    m_oor = 0;
    m_sat = 0;
    m_total = 0;
`endif
    @(posedge clk100); #1;
    dump_req = 1'b1;
    bus.dump_ready = pat(mode, k);
    @(posedge clk100); #1;
    dump_req = 1'b0;
    while (sb.size() > 0 && k < bound) begin
      k++;
      bus.dump_ready = pat(mode, k);
      @(posedge clk100); #1;
    end
    if (sb.size() > 0) begin
      chk("dump_timeout", sb.size(), 0);
      sb.delete();
    end
    bus.dump_ready = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    bus.bin_valid = 1'b0;
    bus.i_bin_coord = '0;
    bus.q_bin_coord = '0;
    bus.dump_ready = 1'b0;

    // reset values
    #12;
    @(negedge clk100);
    chk("rst_bin_ready", bus.bin_ready, 0);
    chk("rst_dump_valid", bus.dump_valid, 0);
    chk("rst_dump_last", bus.dump_last, 0);
    chk("rst_dump_i", bus.dump_i, 0);
    chk("rst_dump_q", bus.dump_q, 0);
    chk("rst_dump_count", bus.dump_count, 0);
    chk("rst_busy", busy, 1);
    chk("rst_sat", sat_flag, 0);
    chk("rst_oor", oor_count, 0);
    chk("rst_total", total_count, 0);
    @(posedge clk100); #1;
    rst_n = 1'b1;
    count_busy(n);
    chk("rst_sweep_len", n, 4096);
    chk("idle_bin_ready", bus.bin_ready, 1);

    // default limits are 1x1
    do_dump(0);
    do_clear(2, 2, "clr_2x2");
    do_dump(0);

    // back-to-back samples at one bin, stalled dump
    do_clear(4, 4, "clr_4x4_a");
    acc_t.delete();
    send_burst(5, 2, 3);
    for (int k = 1; k < 5; k++)
      chk("acc_interval", acc_t[k] - acc_t[k-1], 3);
    chk_counters("burst");
    do_dump(1);

    // out-of-range samples
    do_clear(4, 4, "clr_4x4_b");
    send_burst(1, 63, 0);
    send_burst(1, 0, 63);
    send_burst(1, 4, 1);
    chk_counters("oor");
    do_dump(0);

    // saturation
    do_clear(4, 4, "clr_sat");
    send_burst(NMAX, 0, 0);
    chk_counters("pre_sat");
    send_burst(1, 0, 0);
    chk_counters("sat");
    do_dump(0);
    do_clear(4, 4, "clr_post_sat");
    chk_counters("post_sat");
    do_dump(0);

    // clear in the middle of a dump
    send_burst(3, 1, 1);
    chk_counters("pre_abort");
    push_expected();
    n = sb.size();
    @(posedge clk100); #1;
    dump_req = 1'b1;
    bus.dump_ready = 1'b1;
    @(posedge clk100); #1;
    dump_req = 1'b0;
    for (int t = 0; t < 100 && sb.size() > n - 2; t++) begin
      @(posedge clk100); #1;
    end
    chk("abort_progress", sb.size(), n - 2);
    clear = 1'b1;
    i_bin_num = 3;
    q_bin_num = 5;
    bus.dump_ready = 1'b0;
    @(posedge clk100); #1;
    clear = 1'b0;
    sb.delete();
    model_clear(3, 5);
    @(negedge clk100);
    chk("abort_valid", bus.dump_valid, 0);
    chk("abort_last", bus.dump_last, 0);
    n = 1;
    begin
      int r;
      count_busy(r);
      n += r;
    end
    chk("abort_sweep_len", n, 4096);
    do_dump(0);

    // randomized samples, two dumps back to back
    for (int r = 0; r < 2; r++) begin
      do_clear(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "clr_rand");
      for (int s = 0; s < 60; s++) begin
        int a = ($urandom % 6 == 0) ? 63 : int'($urandom_range(0, 8));
        int b = ($urandom % 6 == 0) ? 63 : int'($urandom_range(0, 8));
        send_burst(1, a, b);
      end
      chk_counters("rand");
      do_dump(2);
      chk_counters("rand_after_dump");
      do_dump(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
